// File: rtl/floo_atop_id_allocator.sv
// floo_atop_id_allocator
// Hands out unique AXI IDs to atomic (ATOP) write bursts and retires them
// once their B response (and R burst, if any) has come back.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   alloc_req_i             ATOP AW waiting for an ID (held until commit)
//   alloc_has_r_i           the ATOP also returns an R burst (sampled at commit)
//   alloc_gnt_o/alloc_id_o  combinational ID offer
//   alloc_commit_i          downstream AW handshake done this cycle
//   b_done_i/b_id_i         B completion for an atomic ID
//   r_done_i/r_id_i         last-beat R completion for an atomic ID
//   outstanding_o           registered count of non-free slots
//   idle_o                  registered: all slots free and no lock held
//   err_o                   registered one-cycle protocol-violation pulse
module floo_atop_id_allocator #(
  parameter int unsigned NumIds  = 4,
  parameter int unsigned IdWidth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_req_i,
  input  logic                         alloc_has_r_i,
  output logic                         alloc_gnt_o,
  output logic [IdWidth-1:0]           alloc_id_o,
  input  logic                         alloc_commit_i,
  input  logic                         b_done_i,
  input  logic [IdWidth-1:0]           b_id_i,
  input  logic                         r_done_i,
  input  logic [IdWidth-1:0]           r_id_i,
  output logic [$clog2(NumIds+1)-1:0]  outstanding_o,
  output logic                         idle_o,
  output logic                         err_o
);

  localparam int unsigned SlotW = (NumIds > 1) ? $clog2(NumIds) : 1;
  localparam int unsigned CntW  = $clog2(NumIds + 1);

  if ((NumIds < 1) || (IdWidth < $clog2(NumIds)) || (NumIds > (2 ** IdWidth))) begin : g_bad_params
    $error("floo_atop_id_allocator: illegal NumIds/IdWidth combination");
  end

  logic [NumIds-1:0] b_pend_q, b_pend_d;
  logic [NumIds-1:0] r_pend_q, r_pend_d;
  logic [NumIds-1:0] free;
  logic              any_free;
  logic [SlotW-1:0]  cand;
  logic              lock_q, lock_d;
  logic [SlotW-1:0]  lock_id_q, lock_id_d;
  logic [SlotW-1:0]  offer_id;
  logic              gnt_c;
  logic              err_q, err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              idle_q, idle_d;
  logic              b_in_range, r_in_range;
  logic [SlotW-1:0]  b_idx, r_idx;

  assign free = ~(b_pend_q | r_pend_q);

  // Lowest-index free slot over registered state only.
  always_comb begin
    any_free = 1'b0;
    cand     = '0;
    for (int i = int'(NumIds) - 1; i >= 0; i--) begin
      if (free[i]) begin
        any_free = 1'b1;
        cand     = SlotW'(i);
      end
    end
  end

  // A held lock pins the offered ID so a stalled AW never sees it change.
  assign offer_id    = lock_q ? lock_id_q : cand;
  assign gnt_c       = alloc_req_i && (lock_q || any_free);
  assign alloc_gnt_o = gnt_c;
  assign alloc_id_o  = gnt_c ? IdWidth'(offer_id) : '0;

  // Range check one bit wider so NumIds == 2**IdWidth does not wrap.
  assign b_in_range = {1'b0, b_id_i} < (IdWidth + 1)'(NumIds);
  assign r_in_range = {1'b0, r_id_i} < (IdWidth + 1)'(NumIds);
  assign b_idx      = SlotW'(b_id_i);
  assign r_idx      = SlotW'(r_id_i);

  // Next-state: completions, commit, lock and violation detection.
  always_comb begin
    b_pend_d  = b_pend_q;
    r_pend_d  = r_pend_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = 1'b0;
    cnt_d     = '0;
    idle_d    = 1'b0;

    if (b_done_i) begin
      if (b_in_range && b_pend_q[b_idx]) b_pend_d[b_idx] = 1'b0;
      else                               err_d = 1'b1;
    end
    if (r_done_i) begin
      if (r_in_range && r_pend_q[r_idx]) r_pend_d[r_idx] = 1'b0;
      else                               err_d = 1'b1;
    end

    // The offered slot is always free, so a commit never collides with a
    // legal completion on the same slot.
    if (alloc_commit_i) begin
      if (gnt_c) begin
        b_pend_d[offer_id] = 1'b1;
        r_pend_d[offer_id] = alloc_has_r_i;
      end else begin
        err_d = 1'b1;
      end
    end

    if (lock_q && !alloc_req_i) begin
      err_d  = 1'b1;
      lock_d = 1'b0;
    end else if (gnt_c) begin
      lock_d    = !alloc_commit_i;
      lock_id_d = offer_id;
    end

    for (int i = 0; i < int'(NumIds); i++) begin
      cnt_d = cnt_d + CntW'(b_pend_d[i] | r_pend_d[i]);
    end
    idle_d = (cnt_d == '0) && !lock_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_pend_q  <= '0;
      r_pend_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= 1'b1;
    end else begin
      b_pend_q  <= b_pend_d;
      r_pend_q  <= r_pend_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = idle_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_floo_atop_id_allocator.sv
// Testbench for floo_atop_id_allocator (NumIds=4, IdWidth=4): directed table,
// hand sequences for reset, and randomized traffic against a slot-level model.
module tb_floo_atop_id_allocator;

  localparam int NIDS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, has_r, commit, b_done, r_done;
  logic [3:0] b_id, r_id;
  logic       gnt, idle, err;
  logic [3:0] id;
  logic [2:0] outst;

  always #5 clk = ~clk;

  floo_atop_id_allocator #(.NumIds(4), .IdWidth(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_req_i(req), .alloc_has_r_i(has_r),
    .alloc_gnt_o(gnt), .alloc_id_o(id),
    .alloc_commit_i(commit),
    .b_done_i(b_done), .b_id_i(b_id),
    .r_done_i(r_done), .r_id_i(r_id),
    .outstanding_o(outst), .idle_o(idle), .err_o(err)
  );

  typedef struct {
    bit req, has_r, commit, b_done;
    int b_id;
    bit r_done;
    int r_id;
    bit gnt;
    int id;
    int outst;
    bit idle, err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: which responses each slot still owes, plus the held offer.
  bit m_owes_b[NIDS];
  bit m_owes_r[NIDS];
  bit m_locked;
  int m_lock_slot;
  int m_out;
  bit m_idle, m_err;

  function automatic vec_t mk(bit rq, bit hr, bit cm, bit bd, int bi, bit rd, int ri,
                              bit g, int i, int o, bit il, bit e);
    vec_t v;
    v.req = rq; v.has_r = hr; v.commit = cm; v.b_done = bd; v.b_id = bi;
    v.r_done = rd; v.r_id = ri; v.gnt = g; v.id = i; v.outst = o; v.idle = il; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NIDS; i++) begin
      m_owes_b[i] = 0;
      m_owes_r[i] = 0;
    end
    m_locked = 0; m_lock_slot = 0; m_out = 0; m_idle = 1; m_err = 0;
  endtask

  function automatic bit slot_free(int s);
    return !m_owes_b[s] && !m_owes_r[s];
  endfunction

  task automatic model_offer(input bit rq, output bit g, output int i);
    g = 0; i = 0;
    if (rq) begin
      if (m_locked) begin
        g = 1; i = m_lock_slot;
      end else begin
        for (int s = NIDS - 1; s >= 0; s--)
          if (slot_free(s)) begin g = 1; i = s; end
      end
    end
  endtask

  task automatic model_step(input vec_t v);
    bit g, e, nb[NIDS], nr[NIDS];
    int i, busy;
    model_offer(v.req, g, i);
    e = 0;
    nb = m_owes_b; nr = m_owes_r;
    if (v.b_done) begin
      if (v.b_id >= NIDS || !m_owes_b[v.b_id]) e = 1; else nb[v.b_id] = 0;
    end
    if (v.r_done) begin
      if (v.r_id >= NIDS || !m_owes_r[v.r_id]) e = 1; else nr[v.r_id] = 0;
    end
    if (v.commit) begin
      if (g) begin nb[i] = 1; nr[i] = v.has_r; end
      else e = 1;
    end
    if (m_locked && !v.req) begin
      e = 1; m_locked = 0;
    end else if (g) begin
      m_locked = !v.commit;
      m_lock_slot = i;
    end
    m_owes_b = nb; m_owes_r = nr;
    busy = 0;
    for (int s = 0; s < NIDS; s++) if (!slot_free(s)) busy++;
    m_out = busy;
    m_idle = (busy == 0) && !m_locked;
    m_err = e;
  endtask

  // Entered just after a rising edge; applies one vector for one cycle.
  task automatic run_cycle(input vec_t v, input bit chk_tbl, input string tag);
    bit g; int i;
    req = v.req; has_r = v.has_r; commit = v.commit;
    b_done = v.b_done; b_id = 4'(v.b_id); r_done = v.r_done; r_id = 4'(v.r_id);
    #4;
    model_offer(v.req, g, i);
    check({tag, " gnt"},   int'(gnt),   int'(g));
    check({tag, " id"},    int'(id),    i);
    check({tag, " outst"}, int'(outst), m_out);
    check({tag, " idle"},  int'(idle),  int'(m_idle));
    check({tag, " err"},   int'(err),   int'(m_err));
    if (chk_tbl) begin
      check({tag, " tbl_gnt"},   int'(gnt),   int'(v.gnt));
      check({tag, " tbl_id"},    int'(id),    v.id);
      check({tag, " tbl_outst"}, int'(outst), v.outst);
      check({tag, " tbl_idle"},  int'(idle),  int'(v.idle));
      check({tag, " tbl_err"},   int'(err),   int'(v.err));
    end
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[28];
  vec_t nop;

  initial begin
    //           rq hr cm bd bi rd ri   g  id out idle err
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 0, 0,   1, 2, 2, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 3, 3, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 3, 3, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 1, 0, 0,   1, 3, 3, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 3, 2, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0,   1, 3, 2, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0,   1, 1, 3, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0,   1, 1, 3, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 4, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 2, 0, 0,   0, 0, 4, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 2,   0, 0, 4, 0, 0);
    tbl[14] = mk(1, 1, 1, 0, 0, 0, 0,   1, 2, 3, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 1, 0,   0, 0, 4, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 0, 0,   0, 0, 3, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 1, 1,   0, 0, 3, 0, 0);
    tbl[20] = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 3, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1);
    tbl[22] = mk(0, 0, 0, 1, 5, 0, 0,   0, 0, 3, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0,   1, 0, 3, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 0);
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    req = 0; has_r = 0; commit = 0; b_done = 0; r_done = 0; b_id = '0; r_id = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int k = 0; k < 28; k++) run_cycle(tbl[k], 1'b1, $sformatf("tbl%0d", k));

    // Build 3 outstanding slots (0,2,3) with a lock held on slot 1.
    run_cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_commit0");
    run_cycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_free1");
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_lock1");
    run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0), 1'b1, "pre_rst_held");

    // Asynchronous reset mid-cycle, observed before any clock edge.
    req = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_rst outst", int'(outst), 0);
    check("async_rst idle",  int'(idle),  1);
    check("async_rst err",   int'(err),   0);
    check("async_rst id",    int'(id),    0);
    model_reset();
    rst = 1'b0;
    run_cycle(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0), 1'b1, "post_rst_first");
    run_cycle(nop, 1'b0, "post_rst_idle");

    // Randomized traffic, mostly legal with occasional violations.
    for (int k = 0; k < 1500; k++) begin
      vec_t v;
      v = nop;
      v.req    = ($urandom_range(0, 3) != 0);
      v.has_r  = $urandom_range(0, 1) != 0;
      v.commit = v.req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      v.b_done = $urandom_range(0, 2) == 0;
      v.b_id   = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      v.r_done = $urandom_range(0, 2) == 0;
      v.r_id   = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      run_cycle(v, 1'b0, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
